// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one management-memory port between NUM_REQ requesters.
// Latency: accept/issue one cycle after the IDLE grant; write response the cycle after; read response one cycle after m_rvalid.
// Backpressure: one transaction in flight; the granted requester's bready/rready stalls the FSM and blocks new grants.
// Optional feature: define ARB_TIMEOUT_EN to end a silent read after TIMEOUT_CYCLES with SLVERR / 0xDEADBEEF.
module shared_mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    s_awvalid,
  input  logic [NUM_REQ*AW-1:0] s_awaddr,
  input  logic [NUM_REQ-1:0]    s_wvalid,
  input  logic [NUM_REQ*DW-1:0] s_wdata,
  output logic [NUM_REQ-1:0]    s_awready,
  output logic [NUM_REQ-1:0]    s_wready,
  output logic [NUM_REQ-1:0]    s_bvalid,
  input  logic [NUM_REQ-1:0]    s_bready,
  output logic [NUM_REQ*2-1:0]  s_bresp,
  input  logic [NUM_REQ-1:0]    s_arvalid,
  input  logic [NUM_REQ*AW-1:0] s_araddr,
  output logic [NUM_REQ-1:0]    s_arready,
  output logic [NUM_REQ-1:0]    s_rvalid,
  input  logic [NUM_REQ-1:0]    s_rready,
  output logic [NUM_REQ*DW-1:0] s_rdata,
  output logic [NUM_REQ*2-1:0]  s_rresp,
  output logic                  m_wvalid,
  output logic [AW-1:0]         m_waddr,
  output logic [DW-1:0]         m_wdata,
  output logic                  m_arvalid,
  output logic [AW-1:0]         m_raddr,
  input  logic                  m_rvalid,
  input  logic [DW-1:0]         m_rdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  m_wvalid_q, m_wvalid_d;
  logic [AW-1:0]         m_waddr_q, m_waddr_d;
  logic [DW-1:0]         m_wdata_q, m_wdata_d;
  logic                  m_arvalid_q, m_arvalid_d;
  logic [AW-1:0]         m_raddr_q, m_raddr_d;
  logic [NUM_REQ-1:0]    wacc_q, wacc_d;
  logic [NUM_REQ-1:0]    s_arready_q, s_arready_d;
  logic [NUM_REQ-1:0]    s_bvalid_q, s_bvalid_d;
  logic [NUM_REQ-1:0]    s_rvalid_q, s_rvalid_d;
  logic [NUM_REQ*DW-1:0] rdata_q, rdata_d;
  logic [NUM_REQ*2-1:0]  rresp_q, rresp_d;

  logic [NUM_REQ-1:0]    wr_pend, rd_pend;
  logic                  arb_found, arb_wr;
  logic [PW-1:0]         arb_idx, cand;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // A write needs both address and data present; half a write is not a request.
  assign wr_pend = s_awvalid & s_wvalid;
  assign rd_pend = s_arvalid;

  // Round-robin search from rr_ptr; within the winner, a write beats a read.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_wr    = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!arb_found && (wr_pend[cand] || rd_pend[cand])) begin
        arb_found = 1'b1;
        arb_idx   = cand;
        arb_wr    = wr_pend[cand];
      end
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    m_waddr_d = m_waddr_q;
    m_wdata_d = m_wdata_q;
    m_raddr_d = m_raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d  = arb_idx;
          rr_ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + PW'(1);
          if (arb_wr) begin
            state_d   = WR_ISSUE;
            m_waddr_d = s_awaddr[arb_idx*AW +: AW];
            m_wdata_d = s_wdata[arb_idx*DW +: DW];
          end else begin
            state_d   = RD_ISSUE;
            m_raddr_d = s_araddr[arb_idx*AW +: AW];
          end
        end
      end
      WR_ISSUE: state_d = WR_RESP;
      WR_RESP:  if (s_bready[grant_q]) state_d = IDLE;
      RD_ISSUE: begin
        state_d = RD_WAIT;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      RD_WAIT: begin
        if (m_rvalid) begin
          state_d                    = RD_RESP;
          rdata_d[grant_q*DW +: DW]  = m_rdata;
          rresp_d[grant_q*2 +: 2]    = 2'b00;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d                    = RD_RESP;
          rdata_d[grant_q*DW +: DW]  = DW'(32'hDEADBEEF);
          rresp_d[grant_q*2 +: 2]    = 2'b10;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RD_RESP:  if (s_rready[grant_q]) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    m_wvalid_d  = (state_d == WR_ISSUE);
    m_arvalid_d = (state_d == RD_ISSUE);
    wacc_d      = '0;
    s_arready_d = '0;
    s_bvalid_d  = '0;
    s_rvalid_d  = '0;
    wacc_d[grant_d]      = (state_d == WR_ISSUE);
    s_arready_d[grant_d] = (state_d == RD_ISSUE);
    s_bvalid_d[grant_d]  = (state_d == WR_RESP);
    s_rvalid_d[grant_d]  = (state_d == RD_RESP);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      m_wvalid_q  <= 1'b0;
      m_waddr_q   <= '0;
      m_wdata_q   <= '0;
      m_arvalid_q <= 1'b0;
      m_raddr_q   <= '0;
      wacc_q      <= '0;
      s_arready_q <= '0;
      s_bvalid_q  <= '0;
      s_rvalid_q  <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      m_wvalid_q  <= m_wvalid_d;
      m_waddr_q   <= m_waddr_d;
      m_wdata_q   <= m_wdata_d;
      m_arvalid_q <= m_arvalid_d;
      m_raddr_q   <= m_raddr_d;
      wacc_q      <= wacc_d;
      s_arready_q <= s_arready_d;
      s_bvalid_q  <= s_bvalid_d;
      s_rvalid_q  <= s_rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign m_wvalid  = m_wvalid_q;
  assign m_waddr   = m_waddr_q;
  assign m_wdata   = m_wdata_q;
  assign m_arvalid = m_arvalid_q;
  assign m_raddr   = m_raddr_q;
  assign s_awready = wacc_q;
  assign s_wready  = wacc_q;
  assign s_arready = s_arready_q;
  assign s_bvalid  = s_bvalid_q;
  assign s_bresp   = '0;
  assign s_rvalid  = s_rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: per-cycle vector table plus hand sequences.
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_awvalid, s_wvalid, s_awready, s_wready, s_bvalid, s_bready;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_bresp, s_rresp;
  logic        m_wvalid, m_arvalid, m_rvalid;
  logic [31:0] m_waddr, m_wdata, m_raddr, m_rdata;

  int tests = 0;
  int fails = 0;
  int cur   = -1;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.NUM_REQ(2), .AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_wvalid(s_wvalid), .s_wdata(s_wdata),
    .s_awready(s_awready), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_wvalid(m_wvalid), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .m_arvalid(m_arvalid), .m_raddr(m_raddr),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  awv, wv, arv, br, rr;
    logic        mrv;
    logic [31:0] mrd;
    logic        mwv, marv;
    logic [1:0]  awr, arr, bv, rv;
    logic [31:0] ma, md;
    logic [63:0] rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic [1:0] awv, input logic [1:0] wv,
                              input logic [1:0] arv, input logic [1:0] br, input logic [1:0] rr,
                              input logic mrv, input logic [31:0] mrd,
                              input logic mwv, input logic marv, input logic [1:0] awr,
                              input logic [1:0] arr, input logic [1:0] bv, input logic [1:0] rv,
                              input logic [31:0] ma, input logic [31:0] md, input logic [63:0] rd);
    vec_t v;
    v.rst = r; v.awv = awv; v.wv = wv; v.arv = arv; v.br = br; v.rr = rr;
    v.mrv = mrv; v.mrd = mrd; v.mwv = mwv; v.marv = marv; v.awr = awr; v.arr = arr;
    v.bv = bv; v.rv = rv; v.ma = ma; v.md = md; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s (vec %0d): got %h, want %h", nm, cur, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; s_awvalid = v.awv; s_wvalid = v.wv; s_arvalid = v.arv;
    s_bready = v.br; s_rready = v.rr; m_rvalid = v.mrv; m_rdata = v.mrd;
  endtask

  task automatic check_vec(input vec_t v);
    chk("m_wvalid",  64'(m_wvalid),  64'(v.mwv));
    chk("m_arvalid", 64'(m_arvalid), 64'(v.marv));
    chk("s_awready", 64'(s_awready), 64'(v.awr));
    chk("s_wready",  64'(s_wready),  64'(v.awr));
    chk("s_arready", 64'(s_arready), 64'(v.arr));
    chk("s_bvalid",  64'(s_bvalid),  64'(v.bv));
    chk("s_rvalid",  64'(s_rvalid),  64'(v.rv));
    if (v.mwv) begin
      chk("m_waddr", 64'(m_waddr), 64'(v.ma));
      chk("m_wdata", 64'(m_wdata), 64'(v.md));
    end
    if (v.marv) chk("m_raddr", 64'(m_raddr), 64'(v.ma));
    if (v.bv != 2'b00) chk("s_bresp", 64'(s_bresp), 64'h0);
    if (v.rv != 2'b00) chk("s_rresp", 64'(s_rresp), 64'h0);
    if (v.rv != 2'b00 || v.rst) chk("s_rdata", s_rdata, v.rd);
    if (v.rst) begin
      chk("rst_m_waddr", 64'(m_waddr), 64'h0);
      chk("rst_m_wdata", 64'(m_wdata), 64'h0);
      chk("rst_m_raddr", 64'(m_raddr), 64'h0);
      chk("rst_resp",    64'({s_bresp, s_rresp}), 64'h0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = 2'b11; s_rready = 2'b11;
    m_rvalid = 1'b0; m_rdata = '0;
    s_awaddr = {32'h20, 32'h10};
    s_wdata  = {32'h5A5A, 32'hA5A5};
    s_araddr = {32'h8, 32'h4};

    // rst awv wv arv br rr mrv mrd | mwv marv awr arr bv rv addr data rdata_bus
    // simultaneous reads after reset, L=2; stray m_rvalid outside RD_WAIT
    vq.push_back(mk(0,2'b00,2'b00,2'b11,2'b11,2'b11,0,32'h0,   0,1,2'b00,2'b01,2'b00,2'b00,32'h4,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b10,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b10,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b10,2'b11,2'b11,1,32'h11,  0,0,2'b00,2'b00,2'b00,2'b01,32'h0,32'h0,64'h00000000_00000011));
    vq.push_back(mk(0,2'b00,2'b00,2'b10,2'b11,2'b11,1,32'h99,  0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b10,2'b11,2'b11,1,32'h77,  0,1,2'b00,2'b10,2'b00,2'b00,32'h8,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,1,32'h22,  0,0,2'b00,2'b00,2'b00,2'b10,32'h0,32'h0,64'h00000022_00000011));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    // continuous writes from both: grants 0,1,0,1, three cycles each
    for (int k = 0; k < 4; k++) begin
      logic [1:0] g;
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      vq.push_back(mk(0,2'b11,2'b11,2'b00,2'b11,2'b11,0,32'h0, 1,0,g,2'b00,2'b00,2'b00,
                      (k % 2 == 0) ? 32'h10 : 32'h20, (k % 2 == 0) ? 32'hA5A5 : 32'h5A5A, 64'h0));
      vq.push_back(mk(0,2'b11,2'b11,2'b00,2'b11,2'b11,0,32'h0, 0,0,2'b00,2'b00,g,2'b00,32'h0,32'h0,64'h0));
      vq.push_back(mk(0,(k == 3) ? 2'b00 : 2'b11,(k == 3) ? 2'b00 : 2'b11,2'b00,2'b11,2'b11,0,32'h0,
                      0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    end
    // req0 write+read, req1 idle: write first, read on the next IDLE (L=1)
    vq.push_back(mk(0,2'b01,2'b01,2'b01,2'b11,2'b11,0,32'h0,   1,0,2'b01,2'b00,2'b00,2'b00,32'h10,32'hA5A5,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b01,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b01,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b01,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b01,2'b11,2'b11,0,32'h0,   0,1,2'b00,2'b01,2'b00,2'b00,32'h4,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,1,32'h33,  0,0,2'b00,2'b00,2'b00,2'b01,32'h0,32'h0,64'h00000022_00000033));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    // req1 write+read, req0 read: req1 write, req0 read, then req1 read under backpressure
    vq.push_back(mk(0,2'b10,2'b10,2'b11,2'b11,2'b11,0,32'h0,   1,0,2'b10,2'b00,2'b00,2'b00,32'h20,32'h5A5A,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b11,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b10,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b11,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b11,2'b11,2'b11,0,32'h0,   0,1,2'b00,2'b01,2'b00,2'b00,32'h4,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b10,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b10,2'b11,2'b11,1,32'h44,  0,0,2'b00,2'b00,2'b00,2'b01,32'h0,32'h0,64'h00000022_00000044));
    vq.push_back(mk(0,2'b00,2'b00,2'b10,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b10,2'b11,2'b11,0,32'h0,   0,1,2'b00,2'b10,2'b00,2'b00,32'h8,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,1,32'h55,  0,0,2'b00,2'b00,2'b00,2'b10,32'h0,32'h0,64'h00000055_00000044));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(0,2'b00,2'b00,2'b01,2'b11,2'b01,(k == 1),32'hEE, 0,0,2'b00,2'b00,2'b00,2'b10,32'h0,32'h0,64'h00000055_00000044));
    vq.push_back(mk(0,2'b00,2'b00,2'b01,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    // reset while waiting on memory; late m_rvalid must not produce a response
    vq.push_back(mk(0,2'b00,2'b00,2'b01,2'b11,2'b11,0,32'h0,   0,1,2'b00,2'b01,2'b00,2'b00,32'h4,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(1,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,1,32'h66,  0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    // reset while bvalid is stalled; rr_ptr must return to 0
    vq.push_back(mk(0,2'b01,2'b01,2'b00,2'b11,2'b11,0,32'h0,   1,0,2'b01,2'b00,2'b00,2'b00,32'h10,32'hA5A5,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b00,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b01,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b00,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b01,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(1,2'b00,2'b00,2'b00,2'b00,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b11,2'b11,2'b00,2'b11,2'b11,0,32'h0,   1,0,2'b01,2'b00,2'b00,2'b00,32'h10,32'hA5A5,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b01,2'b00,32'h0,32'h0,64'h0));
    vq.push_back(mk(0,2'b00,2'b00,2'b00,2'b11,2'b11,0,32'h0,   0,0,2'b00,2'b00,2'b00,2'b00,32'h0,32'h0,64'h0));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", 64'({m_wvalid, m_arvalid, s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 64'h0);
    chk("rst_mbus",   64'({m_waddr, m_wdata}), 64'h0);
    chk("rst_raddr",  64'(m_raddr), 64'h0);
    chk("rst_rdata",  s_rdata, 64'h0);
    chk("rst_resp",   64'({s_bresp, s_rresp}), 64'h0);

    for (int i = 0; i < vq.size(); i++) begin
      cur = i;
      apply(vq[i]);
      step();
      check_vec(vq[i]);
    end

    // read from req1 with memory latency 5 (rr_ptr is 1 here)
    cur = 1000;
    rst = 1'b0; s_awvalid = '0; s_wvalid = '0; s_bready = 2'b11; s_rready = 2'b11;
    m_rvalid = 1'b0; s_arvalid = 2'b10;
    step();
    chk("l5_arvalid", 64'({m_arvalid, s_arready}), 64'({1'b1, 2'b10}));
    chk("l5_raddr", 64'(m_raddr), 64'h8);
    s_arvalid = 2'b00;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("l5_wait_rvalid", 64'(s_rvalid), 64'h0);
    end
    m_rvalid = 1'b1; m_rdata = 32'hCAFE;
    step();
    m_rvalid = 1'b0;
    chk("l5_rvalid", 64'(s_rvalid), 64'h2);
    chk("l5_rdata", s_rdata, 64'h0000CAFE_00000000);
    step();
    chk("l5_done", 64'(s_rvalid), 64'h0);

`ifdef ARB_TIMEOUT_EN
    // silent memory: req0 read ends after 8 RD_WAIT cycles with SLVERR
    cur = 2000;
    s_arvalid = 2'b01;
    step();
    chk("to_arvalid", 64'(m_arvalid), 64'h1);
    s_arvalid = 2'b00;
    n = 0;
    while (s_rvalid[0] !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("to_latency", 64'(n), 64'd9);
    chk("to_rresp", 64'(s_rresp[1:0]), 64'h2);
    chk("to_rdata", 64'(s_rdata[31:0]), 64'hDEADBEEF);
    s_rready = 2'b00; m_rvalid = 1'b1; m_rdata = 32'h12345678;
    step();
    m_rvalid = 1'b0;
    chk("to_hold_rvalid", 64'(s_rvalid), 64'h1);
    chk("to_hold_rdata", 64'(s_rdata[31:0]), 64'hDEADBEEF);
    s_rready = 2'b11;
    step();
    chk("to_done", 64'(s_rvalid), 64'h0);
`else
    n = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
